// File: rtl/la_capture_sequencer_if.sv
// Capture stream from the sequencer to the host DMA: one 32-bit word per
// valid/ready handshake, with last marking the final word of each capture.
interface la_capture_sequencer_if;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/la_capture_sequencer.sv
// Sequences one logic-analyzer capture engine through N captures and drains each buffer onto a stream.
// Optional ARM-state timeout is compiled in when LA_SEQ_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for cmd_start
// SETUP   | la_set_strobe pulse
// WAIT    | down-counter delay (settle or read latency), then go to wait_ret
// ARM     | engine enabled, waiting for la_finished
// LOAD    | capture la_data into the stream register
// PRESENT | word offered on the stream until accepted
// STEP    | la_read_strobe pulse to advance the read pointer
// RESTART | count the capture; finish or pulse la_restart
module la_capture_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_start,
   input  logic                   cmd_abort,
   input  logic [COUNT_WIDTH-1:0] cfg_capture_count,
   input  logic [31:0]            cfg_timeout,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] captures_done,
   output logic                   la_set_strobe,
   output logic                   la_enable,
   output logic                   la_restart,
   input  logic                   la_finished,
   input  logic [31:0]            la_read_size,
   output logic                   la_read_strobe,
   input  logic [31:0]            la_data,
   la_capture_sequencer_if.master m_stream
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_SETUP   = 4'd1;
   localparam logic [3:0] S_WAIT    = 4'd2;
   localparam logic [3:0] S_ARM     = 4'd3;
   localparam logic [3:0] S_LOAD    = 4'd4;
   localparam logic [3:0] S_PRESENT = 4'd5;
   localparam logic [3:0] S_STEP    = 4'd6;
   localparam logic [3:0] S_RESTART = 4'd7;

   localparam logic [31:0] SETTLE_LOAD   = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] READ_LAT_LOAD = 32'd1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

   logic [3:0]             state;
   logic [3:0]             wait_ret;
   logic [31:0]            wait_cnt;
   logic [31:0]            words_left;
   logic [COUNT_WIDTH-1:0] target;
   logic [COUNT_WIDTH-1:0] cap_cnt;
   logic [COUNT_WIDTH-1:0] cap_next;
   logic                   final_capture;
   logic                   enable_q;
   logic                   done_q;
   logic                   error_q;
   logic                   valid_q;
   logic                   last_q;
   logic [31:0]            data_q;
   logic                   tmo_hit;

   assign cap_next      = cap_cnt + CNT_ONE;
   assign final_capture = (cap_next == target);

`ifdef LA_SEQ_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   // Counts cycles already spent in ARM; cleared whenever ARM is left so re-entry starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= 32'd0;
      end else if (state == S_ARM && !cmd_abort) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
         tmo_cnt <= 32'd0;
      end
   end

   assign tmo_hit = (state == S_ARM) && (cfg_timeout != 32'd0) &&
                    ((tmo_cnt + 32'd1) == cfg_timeout);
`else
   logic unused_timeout;
   assign unused_timeout = ^cfg_timeout;
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wait_ret   <= S_IDLE;
         wait_cnt   <= 32'd0;
         words_left <= 32'd0;
         target     <= CNT_ZERO;
         cap_cnt    <= CNT_ZERO;
         enable_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         data_q     <= 32'd0;
      end else if (cmd_abort) begin
         // Abort beats everything, including a same-cycle start; counts are left as they stand.
         state    <= S_IDLE;
         wait_cnt <= 32'd0;
         enable_q <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_start) begin
                  target  <= (cfg_capture_count == CNT_ZERO) ? CNT_ONE : cfg_capture_count;
                  cap_cnt <= CNT_ZERO;
                  error_q <= 1'b0;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               wait_cnt <= SETTLE_LOAD;
               wait_ret <= S_ARM;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == 32'd0) begin
                  state <= wait_ret;
                  if (wait_ret == S_ARM) begin
                     enable_q <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 32'd1;
               end
            end
            S_ARM: begin
               if (la_finished) begin
                  words_left <= la_read_size;
                  if (la_read_size == 32'd0) begin
                     state <= S_RESTART;
                  end else begin
                     wait_cnt <= SETTLE_LOAD;
                     wait_ret <= S_LOAD;
                     state    <= S_WAIT;
                  end
               end else if (tmo_hit) begin
                  error_q  <= 1'b1;
                  enable_q <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            S_LOAD: begin
               data_q  <= la_data;
               valid_q <= 1'b1;
               last_q  <= (words_left == 32'd1);
               state   <= S_PRESENT;
            end
            S_PRESENT: begin
               if (m_stream.m_ready) begin
                  valid_q    <= 1'b0;
                  last_q     <= 1'b0;
                  words_left <= words_left - 32'd1;
                  state      <= (words_left == 32'd1) ? S_RESTART : S_STEP;
               end
            end
            S_STEP: begin
               wait_cnt <= READ_LAT_LOAD;
               wait_ret <= S_LOAD;
               state    <= S_WAIT;
            end
            S_RESTART: begin
               cap_cnt <= cap_next;
               if (final_capture) begin
                  enable_q <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  wait_cnt <= SETTLE_LOAD;
                  wait_ret <= S_ARM;
                  state    <= S_WAIT;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy           = (state != S_IDLE);
   assign done           = done_q;
   assign error          = error_q;
   assign captures_done  = cap_cnt;
   assign la_enable      = enable_q;
   assign la_set_strobe  = (state == S_SETUP);
   assign la_read_strobe = (state == S_STEP);
   // Restart only when another capture follows; the last RESTART cycle just retires the run.
   assign la_restart     = (state == S_RESTART) && !final_capture;

   assign m_stream.m_data  = data_q;
   assign m_stream.m_valid = valid_q;
   assign m_stream.m_last  = last_q;

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Self-checking bench for la_capture_sequencer: engine model, stream scoreboard, table and random runs.
module tb_la_capture_sequencer;
   localparam int SETTLE = 4;
   localparam int CW     = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_start = 1'b0;
   logic          cmd_abort = 1'b0;
   logic [CW-1:0] cfg_capture_count = '0;
   logic [31:0]   cfg_timeout = 32'd0;
   logic          busy, done, error;
   logic [CW-1:0] captures_done;
   logic          la_set_strobe, la_enable, la_restart, la_read_strobe;
   logic          la_finished = 1'b0;
   logic [31:0]   la_read_size = 32'd0;
   logic [31:0]   la_data;

   la_capture_sequencer_if stream_if ();

   la_capture_sequencer #(.SETTLE_CYCLES(SETTLE), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
      .cfg_capture_count(cfg_capture_count), .cfg_timeout(cfg_timeout),
      .busy(busy), .done(done), .error(error), .captures_done(captures_done),
      .la_set_strobe(la_set_strobe), .la_enable(la_enable), .la_restart(la_restart),
      .la_finished(la_finished), .la_read_size(la_read_size),
      .la_read_strobe(la_read_strobe), .la_data(la_data), .m_stream(stream_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // engine model and stream monitor state
   int          cyc = 0;
   int          ready_mode = 0;
   int          arm_delay = 3;
   bit          hold_unfin = 1'b0;
   bit          skip_stall = 1'b0;
   logic [31:0] data_base = 32'd0;
   logic [31:0] eng_ptr = 32'd0;
   logic [31:0] eng_cap = 32'd0;
   int          eng_cnt = 0;
   bit          r = 1'b0;
   bit          stall_pend = 1'b0;
   logic [31:0] held = 32'd0;
   bit          prev_en = 1'b0;
   bit          prev_valid = 1'b0;
   logic [32:0] got[$];
   int          t_valid[$];
   int          n_rd, n_rs, n_set, n_done, stall_viol, multi_viol, en_cycles;
   int          t_set, t_en, t_fin, t_last_hs, t_done;

   assign la_data = data_base + eng_cap * 32'h10 + eng_ptr;

   always @(negedge clk) begin
      cyc++;
      if (la_set_strobe) begin
         eng_ptr = 0; eng_cap = 0; la_finished = 1'b0; eng_cnt = 0;
      end else if (la_restart) begin
         eng_ptr = 0; eng_cap++; la_finished = 1'b0; eng_cnt = 0;
      end else begin
         if (la_read_strobe) eng_ptr++;
         if (la_enable && !la_finished && !hold_unfin) begin
            if (eng_cnt >= arm_delay) begin
               la_finished = 1'b1;
               if (t_fin < 0) t_fin = cyc;
            end else begin
               eng_cnt++;
            end
         end
      end
      if (stall_pend && !skip_stall &&
          (stream_if.m_valid !== 1'b1 || stream_if.m_data !== held)) stall_viol++;
      stall_pend = 1'b0;
      case (ready_mode)
         1:       r = ~r;
         2:       r = 1'($urandom_range(0, 1));
         3:       r = (got.size() == 0);
         default: r = 1'b1;
      endcase
      stream_if.m_ready = r;
      if (stream_if.m_valid) begin
         if (!prev_valid) t_valid.push_back(cyc);
         if (r) begin
            got.push_back({stream_if.m_last, stream_if.m_data});
            if (stream_if.m_last) t_last_hs = cyc;
         end else begin
            stall_pend = 1'b1;
            held = stream_if.m_data;
         end
      end
      prev_valid = stream_if.m_valid;
      if (int'(la_set_strobe) + int'(la_restart) + int'(la_read_strobe) > 1) multi_viol++;
      if (la_set_strobe) begin n_set++; if (t_set < 0) t_set = cyc; end
      if (la_restart) n_rs++;
      if (la_read_strobe) n_rd++;
      if (la_enable && !prev_en && t_en < 0) t_en = cyc;
      prev_en = la_enable;
      if (la_enable) en_cycles++;
      if (done) begin n_done++; t_done = cyc; end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_run(input int cnt, input int size, input int rmode, input int adly,
                            input logic [31:0] base);
      @(negedge clk);
      ready_mode = rmode; arm_delay = adly; data_base = base;
      cfg_capture_count = CW'(cnt); la_read_size = 32'(size);
      got.delete(); t_valid.delete();
      n_rd = 0; n_rs = 0; n_set = 0; n_done = 0; stall_viol = 0; multi_viol = 0; en_cycles = 0;
      t_set = -1; t_en = -1; t_fin = -1; t_last_hs = -1; t_done = -1;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("start_to_set_strobe", la_set_strobe, 1);
      chk("error_cleared_on_start", error, 0);
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   // Reference: every capture yields size words base+16*capture+index, last on the final index.
   task automatic check_run(input string name, input int cnt, input int size, input logic [31:0] base,
                            input int e_words, input int e_strobes, input int e_restarts, input int e_cap);
      logic [32:0] exp_q[$];
      int n;
      n = (cnt == 0) ? 1 : cnt;
      for (int c = 0; c < n; c++)
         for (int i = 0; i < size; i++)
            exp_q.push_back({(i == size - 1), base + 32'(c * 16 + i)});
      chk({name, "_words"}, got.size(), e_words);
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk({name, "_word"}, got[i], exp_q[i]);
      chk({name, "_read_strobes"}, n_rd, e_strobes);
      chk({name, "_restarts"}, n_rs, e_restarts);
      chk({name, "_set_strobes"}, n_set, 1);
      chk({name, "_done_pulses"}, n_done, 1);
      chk({name, "_captures_done"}, captures_done, e_cap);
      chk({name, "_stall_stable"}, stall_viol, 0);
      chk({name, "_one_strobe"}, multi_viol, 0);
      chk({name, "_busy_after"}, busy, 0);
      chk({name, "_enable_after"}, la_enable, 0);
   endtask

   typedef struct {
      int count; int size; int rmode;
      int exp_words; int exp_strobes; int exp_restarts; int exp_cap;
   } vec_t;

   vec_t vecs[4];
   bit   ok;
   int   rc, rs, ra, nn;
   logic [31:0] rb;

   initial begin
      vecs[0] = '{count: 1, size: 4, rmode: 0, exp_words: 4, exp_strobes: 3, exp_restarts: 0, exp_cap: 1};
      vecs[1] = '{count: 3, size: 2, rmode: 1, exp_words: 6, exp_strobes: 3, exp_restarts: 2, exp_cap: 3};
      vecs[2] = '{count: 0, size: 0, rmode: 0, exp_words: 0, exp_strobes: 0, exp_restarts: 0, exp_cap: 1};
      vecs[3] = '{count: 2, size: 1, rmode: 2, exp_words: 2, exp_strobes: 0, exp_restarts: 1, exp_cap: 2};

      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_outputs", {done, error, la_enable, la_set_strobe, la_restart, la_read_strobe,
                            stream_if.m_valid, stream_if.m_last}, 0);
      chk("reset_captures_done", captures_done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", busy, 0);

      // start and abort together while idle: nothing starts
      cmd_start = 1'b1; cmd_abort = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; cmd_abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_no_setup", la_set_strobe, 0);

      for (int v = 0; v < 4; v++) begin
         start_run(vecs[v].count, vecs[v].size, vecs[v].rmode, 3, 32'hA0);
         wait_done(3000, ok);
         chk("table_done_seen", ok, 1);
         repeat (3) @(negedge clk);
         check_run("table", vecs[v].count, vecs[v].size, 32'hA0, vecs[v].exp_words,
                   vecs[v].exp_strobes, vecs[v].exp_restarts, vecs[v].exp_cap);
         if (v == 0) begin
            chk("set_to_enable", t_en - t_set, SETTLE + 1);
            chk("finished_to_valid", t_valid.size() > 0 ? t_valid[0] - t_fin : -1, SETTLE + 2);
            for (int k = 0; k + 1 < t_valid.size(); k++)
               chk("word_period", t_valid[k+1] - t_valid[k], 5);
            chk("last_hs_to_done", t_done - t_last_hs, 2);
         end
      end

      // abort while word 2 of 4 is stalled in PRESENT
      skip_stall = 1'b1;
      start_run(1, 4, 3, 2, 32'hB0);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (stream_if.m_valid && got.size() == 1 && !stream_if.m_ready) begin ok = 1'b1; break; end
      end
      chk("abort_reach_word2", ok, 1);
      chk("abort_word2_data", stream_if.m_data, 32'hB1);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      chk("abort_valid", stream_if.m_valid, 0);
      chk("abort_enable", la_enable, 0);
      chk("abort_busy", busy, 0);
      chk("abort_strobes", {la_set_strobe, la_restart, la_read_strobe}, 0);
      chk("abort_captures_hold", captures_done, 0);
      repeat (20) @(negedge clk);
      chk("abort_no_done", n_done, 0);
      skip_stall = 1'b0;
      start_run(1, 4, 0, 1, 32'hC0);
      wait_done(3000, ok);
      chk("after_abort_done_seen", ok, 1);
      repeat (3) @(negedge clk);
      check_run("after_abort", 1, 4, 32'hC0, 4, 3, 0, 1);

      // randomized runs against the reference, with an ignored mid-run start
      for (int it = 0; it < 8; it++) begin
         rc = $urandom_range(0, 3); rs = $urandom_range(0, 5);
         ra = $urandom_range(0, 6); rb = $urandom;
         start_run(rc, rs, 2, ra, rb);
         repeat (2) @(negedge clk);
         cfg_capture_count = CW'(5);
         cmd_start = 1'b1;
         @(negedge clk);
         cmd_start = 1'b0;
         wait_done(4000, ok);
         chk("rand_done_seen", ok, 1);
         repeat (3) @(negedge clk);
         nn = (rc == 0) ? 1 : rc;
         check_run("rand", rc, rs, rb, nn * rs, (rs == 0) ? 0 : nn * (rs - 1), nn - 1, nn);
      end

      // asynchronous reset in the middle of ARM
      skip_stall = 1'b1;
      start_run(2, 4, 0, 40, 32'hD0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (la_enable) begin ok = 1'b1; break; end
      end
      chk("reset_reach_arm", ok, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_busy", busy, 0);
      chk("async_reset_outputs", {done, error, la_enable, la_set_strobe, la_restart, la_read_strobe,
                                  stream_if.m_valid, stream_if.m_last}, 0);
      chk("async_reset_data", stream_if.m_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_reset_busy", busy, 0);
      skip_stall = 1'b0;

`ifdef LA_SEQ_TIMEOUT_EN
      hold_unfin = 1'b1; cfg_timeout = 32'd50;
      start_run(1, 4, 0, 0, 32'hE0);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      chk("timeout_exit", ok, 1);
      chk("timeout_error", error, 1);
      chk("timeout_enable", la_enable, 0);
      chk("timeout_arm_cycles", en_cycles, 50);
      repeat (3) @(negedge clk);
      chk("timeout_no_done", n_done, 0);
      hold_unfin = 1'b0; cfg_timeout = 32'd0;
      start_run(1, 2, 0, 2, 32'hF0);
      wait_done(3000, ok);
      chk("post_timeout_done_seen", ok, 1);
      repeat (3) @(negedge clk);
      check_run("post_timeout", 1, 2, 32'hF0, 2, 1, 0, 1);
`else
      hold_unfin = 1'b1; cfg_timeout = 32'd50;
      start_run(1, 4, 0, 0, 32'hE0);
      repeat (1000) @(negedge clk);
      chk("no_timeout_busy", busy, 1);
      chk("no_timeout_error", error, 0);
      chk("no_timeout_done", n_done, 0);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      chk("no_timeout_abort", busy, 0);
      hold_unfin = 1'b0; cfg_timeout = 32'd0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
